// File: rtl/block_map.sv
// ============================================================================
// Module   : block_map
// Purpose  : 16x13 brick-field store for breakout. Clears the brick hit by the
//            ball (divider-free pixel-to-index), at most one per frame, and
//            tracks the remaining brick count.
// Options  : BLOCK_MAP_SCORE_EN builds a saturating 10-bit score counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_map #(
  parameter int           BLOCK_X0     = 60,
  parameter int           BLOCK_Y0     = 40,
  parameter int           BLOCK_W      = 40,
  parameter int           BLOCK_H      = 8,
  parameter logic [207:0] INIT_PATTERN = {208{1'b1}}
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         frame_pulse,
  input  logic         collision,
  input  logic [9:0]   hpos,
  input  logic [8:0]   vpos,
  input  logic         reload,
  output logic [207:0] block_state,
  output logic [7:0]   remaining,
  output logic         all_cleared,
  output logic         hit,
  output logic         busy,
  output logic [9:0]   score
);

  localparam int NUM_COLS = 13;
  localparam int NUM_ROWS = 16;

  function automatic logic [7:0] popcount(input logic [207:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 208; i++) begin
      if (v[i]) n++;
    end
    return 8'(n);
  endfunction

  localparam logic [7:0]  INIT_COUNT = popcount(INIT_PATTERN);
  localparam logic [10:0] X_LO       = 11'(BLOCK_X0);
  localparam logic [10:0] X_HI       = 11'(BLOCK_X0 + NUM_COLS * BLOCK_W);
  localparam logic [9:0]  Y_LO       = 10'(BLOCK_Y0);
  localparam logic [9:0]  Y_HI       = 10'(BLOCK_Y0 + NUM_ROWS * BLOCK_H);
  localparam logic [9:0]  W_STEP     = 10'(BLOCK_W);
  localparam logic [8:0]  H_STEP     = 9'(BLOCK_H);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIVX  = 3'd1,
    DIVY  = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        frame_pend;
  logic        reload_pend;
  logic        in_range;
  logic        accept;
  logic        restore;
  logic        clr;
  logic [7:0]  idx;

  assign in_range = ({1'b0, hpos} >= X_LO) && ({1'b0, hpos} < X_HI) &&
                    ({1'b0, vpos} >= Y_LO) && ({1'b0, vpos} < Y_HI);
  assign accept   = (state == IDLE) && collision && in_range;
  // A pending reload takes effect on the frame strobe and aborts any work.
  assign restore  = frame_pulse && reload_pend;
  assign idx      = 8'(row) * 8'd13 + 8'(col);
  assign clr      = (state == CLEAR) && !restore && block_state[idx];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    busy    = 1'b0;
    case (state)
      IDLE:  if (accept) state_d = DIVX;
      DIVX: begin
        busy = 1'b1;
        if (x < W_STEP) state_d = DIVY;
      end
      DIVY: begin
        busy = 1'b1;
        if (y < H_STEP) state_d = CLEAR;
      end
      CLEAR: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE:    if (frame_pulse || frame_pend) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (restore) state_d = IDLE;
  end

  // Repeated-subtraction divide: one quotient step per clock.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      x   <= '0;
      y   <= '0;
      col <= '0;
      row <= '0;
    end else if (accept) begin
      x   <= hpos - X_LO[9:0];
      y   <= vpos - Y_LO[8:0];
      col <= '0;
      row <= '0;
    end else if (state == DIVX && x >= W_STEP) begin
      x   <= x - W_STEP;
      col <= col + 4'd1;
    end else if (state == DIVY && y >= H_STEP) begin
      y   <= y - H_STEP;
      row <= row + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      frame_pend  <= 1'b0;
      reload_pend <= 1'b0;
    end else begin
      // A frame strobe seen mid-operation releases DONE without waiting.
      if (restore || state == DONE)  frame_pend <= 1'b0;
      else if (frame_pulse && busy)  frame_pend <= 1'b1;

      if (restore)     reload_pend <= 1'b0;
      else if (reload) reload_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      block_state <= INIT_PATTERN;
      remaining   <= INIT_COUNT;
      all_cleared <= (INIT_COUNT == 8'd0);
      hit         <= 1'b0;
    end else begin
      hit         <= clr;
      all_cleared <= (remaining == 8'd0);
      if (restore) begin
        block_state <= INIT_PATTERN;
        remaining   <= INIT_COUNT;
      end else if (clr) begin
        block_state[idx] <= 1'b0;
        remaining        <= remaining - 8'd1;
      end
    end
  end

`ifdef BLOCK_MAP_SCORE_EN
  logic [9:0] score_cnt;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)                             score_cnt <= '0;
    else if (clr && score_cnt != 10'h3FF)  score_cnt <= score_cnt + 10'd1;
  end

  assign score = score_cnt;
`else
  assign score = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_block_map.sv
// ============================================================================
// Module   : tb_block_map
// Purpose  : Scoreboard bench for block_map; directed collisions queue their
//            expected hit, a negedge monitor pops and checks each hit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_map;

`ifdef BLOCK_MAP_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         nRst = 1'b0;
  logic         frame_pulse = 1'b0;
  logic         collision = 1'b0;
  logic [9:0]   hpos = '0;
  logic [8:0]   vpos = '0;
  logic         reload = 1'b0;
  logic [207:0] block_state;
  logic [7:0]   remaining;
  logic         all_cleared;
  logic         hit;
  logic         busy;
  logic [9:0]   score;

  block_map dut (
    .clk         (clk),
    .nRst        (nRst),
    .frame_pulse (frame_pulse),
    .collision   (collision),
    .hpos        (hpos),
    .vpos        (vpos),
    .reload      (reload),
    .block_state (block_state),
    .remaining   (remaining),
    .all_cleared (all_cleared),
    .hit         (hit),
    .busy        (busy),
    .score       (score)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int idx;
    int rem;
    int score;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           failures = 0;
  logic [207:0] model;
  int           model_rem;
  int           model_score;
  bit           chk_ac = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_map(input string name, input logic [207:0] act, input logic [207:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_pulse = 1'b1;
    tick();
    frame_pulse = 1'b0;
  endtask

  // Drive one collision cycle; queue the expected hit when a clear is due.
  task automatic collide(input int h, input int v, input int c, input int r,
                         input bit exp_hit, input bit fp);
    exp_t e;
    hpos        = 10'(h);
    vpos        = 9'(v);
    collision   = 1'b1;
    frame_pulse = fp;
    tick();
    collision   = 1'b0;
    frame_pulse = 1'b0;
    if (exp_hit) begin
      chk("busy_after_accept", int'(busy), 1);
      e.idx = r * 13 + c;
      model[e.idx] = 1'b0;
      model_rem--;
      if (SCORE_EN && model_score < 1023) model_score++;
      e.cyc   = cyc + c + r + 3;
      e.rem   = model_rem;
      e.score = model_score;
      q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) tick();
    chk("busy_timeout", int'(busy), 0);
    tick();
    tick();
  endtask

  always @(negedge clk) begin
    if (chk_ac) begin
      chk("all_cleared_late", int'(all_cleared), 1);
      chk_ac = 1'b0;
    end
    if (nRst && hit) begin
      if (q.size() == 0) begin
        chk("unexpected_hit", int'(hit), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("hit_cycle", cyc, e.cyc);
        chk("hit_bit_cleared", int'(block_state[e.idx]), 0);
        chk("hit_remaining", int'(remaining), e.rem);
        chk("hit_score", int'(score), e.score);
        if (e.rem == 0) begin
          chk("all_cleared_early", int'(all_cleared), 0);
          chk_ac = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model       = {208{1'b1}};
    model_rem   = 208;
    model_score = 0;

    repeat (3) tick();
    nRst = 1'b1;
    tick();
    chk_map("reset_block_state", block_state, {208{1'b1}});
    chk("reset_remaining", int'(remaining), 208);
    chk("reset_all_cleared", int'(all_cleared), 0);
    chk("reset_hit", int'(hit), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_score", int'(score), 0);

    // (145,57) -> col 2, row 2, bit 28, hit at E+7
    frame();
    collide(145, 57, 2, 2, 1'b1, 1'b0);
    wait_idle();
    chk_map("map_after_28", block_state, model);

    // Second collision in the same frame is ignored
    collide(300, 100, 6, 7, 1'b0, 1'b0);
    chk("second_in_frame_busy", int'(busy), 0);
    repeat (20) tick();
    chk("second_in_frame_remaining", int'(remaining), 207);

    // Next frame: (300,100) -> col 6, row 7, bit 97
    frame();
    collide(300, 100, 6, 7, 1'b1, 1'b0);
    wait_idle();
    chk_map("map_after_97", block_state, model);

    // Already-cleared brick: no hit, count unchanged
    frame();
    collide(145, 57, 2, 2, 1'b0, 1'b0);
    chk("dup_busy", int'(busy), 1);
    wait_idle();
    chk("dup_remaining", int'(remaining), 206);

    // Out-of-range collision leaves the FSM idle
    frame();
    collide(30, 57, 0, 0, 1'b0, 1'b0);
    chk("oor_busy", int'(busy), 0);
    tick();
    chk("oor_busy_later", int'(busy), 0);

    // Reload, then frame strobe while the divider is running
    reload = 1'b1;
    tick();
    reload = 1'b0;
    collide(565, 160, 12, 15, 1'b0, 1'b0);
    chk("reload_busy_divx", int'(busy), 1);
    tick();
    tick();
    frame();
    model     = {208{1'b1}};
    model_rem = 208;
    chk("reload_busy", int'(busy), 0);
    chk_map("reload_map", block_state, {208{1'b1}});
    chk("reload_remaining", int'(remaining), 208);
    chk("reload_score", int'(score), model_score);
    repeat (40) tick();
    chk("reload_all_cleared", int'(all_cleared), 0);

    // Frame strobe coincident with a collision in IDLE: collision accepted
    collide(145, 57, 2, 2, 1'b1, 1'b1);
    wait_idle();

    // Clear the rest of the field, one brick per frame
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 13; c++) begin
        if (model[r * 13 + c]) begin
          frame();
          collide(60 + c * 40 + (c * 7) % 40, 40 + r * 8 + r % 8, c, r, 1'b1, 1'b0);
          wait_idle();
        end
      end
    end

    chk("final_remaining", int'(remaining), 0);
    chk("final_all_cleared", int'(all_cleared), 1);
    chk_map("final_map", block_state, '0);
    chk("final_score", int'(score), SCORE_EN ? 210 : 0);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
